pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
Pipeline sequencer for the 5-stage core. It owns every stall, bubble and flush enable around the decode stage (PC, IF/ID, ID/EX, EX/MEM, MEM/WB):
- load-use hazard detection on the rs1/rs2/rd fields decoded in ID;
- taken-branch/jump squash resolved in EX;
- data-memory wait freeze;
- a halt/drain/resume handshake for the debug port.

It also keeps saturating stall/flush performance counters.

Parameters:
CNT_W, 32, width of perf counters
DRAIN_CYCLES, 3, non-stalled cycles needed to empty EX/MEM/WB

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
ID_rs1  in  5  rs1 of instruction in ID
ID_rs2  in  5  rs2 of instruction in ID
ID_alusrc  in  1  ID uses immediate as operand B
ID_memwrite  in  1  ID is a store (uses rs2 despite alusrc)
ID_EX_memread  in  1  instruction in EX is a load
ID_EX_rd  in  5  rd of instruction in EX
EX_branch_taken  in  1  EX resolved taken branch or jal; target valid
EX_MEM_mem_access  in  1  MEM stage performs load/store
dmem_ready  in  1  data memory completes access this cycle
halt_req  in  1  level, debug halt request
resume  in  1  pulse, leave halt
pc_write  out  1  PC register load enable
IF_ID_write  out  1  IF/ID load enable
IF_ID_flush  out  1  IF/ID loads NOP
ID_EX_write  out  1  ID/EX load enable
ID_EX_flush  out  1  ID/EX loads bubble (all control 0)
EX_MEM_write  out  1  EX/MEM load enable
MEM_WB_flush  out  1  MEM/WB loads bubble (regwrite 0)
halted  out  1  core halted
stall_cnt  out  CNT_W  cycles with pc_write=0 outside BOOT/HALTED
flush_cnt  out  CNT_W  taken-branch squash events

Behaviour:
- State register: BOOT, RUN, DRAIN, HALTED.
  - rst_n low forces BOOT asynchronously, drain counter to DRAIN_CYCLES, and both perf counters to 0.
- Outputs are decoded from state plus current inputs. Reset and BOOT values: pc_write=0, IF_ID_write=0, IF_ID_flush=1, ID_EX_write=1, ID_EX_flush=1, EX_MEM_write=1, MEM_WB_flush=1, halted=0.
- BOOT lasts one cycle after reset release, then goes to RUN.
- mem_stall = EX_MEM_mem_access & !dmem_ready.
- uses_rs2 = !ID_alusrc | ID_memwrite.
- load_use = ID_EX_memread & ID_EX_rd!=0 & (ID_EX_rd==ID_rs1 | (uses_rs2 & ID_EX_rd==ID_rs2)).
- Defaults (all states except BOOT): every write enable=1, every flush=0, halted=0.
- Priority within RUN/DRAIN is mem_stall > branch > load_use/drain hold. The actions are:
  - mem_stall: pc_write=IF_ID_write=ID_EX_write=EX_MEM_write=0, MEM_WB_flush=1. A branch or load-use in the same cycle is ignored and re-evaluated next cycle, because the pipeline is frozen.
  - EX_branch_taken: pc_write=1, IF_ID_flush=1, ID_EX_flush=1. Any coincident load_use is discarded because the ID instruction is squashed.
  - load_use in RUN: pc_write=0, IF_ID_write=0, ID_EX_flush=1. This is exactly one bubble per load-use pair.
- RUN → DRAIN at the edge when halt_req=1 and mem_stall=0. Both the cycle that samples halt_req and the cycle of the transition execute normally.
- DRAIN: pc_write=0, IF_ID_write=0, ID_EX_flush=1, so ID is held and not issued.
  - Taken-branch rule still applies: pc_write=1 and IF_ID_flush=1, so the redirect is preserved.
  - The counter decrements on every cycle with mem_stall=0. When it would reach 0, go to HALTED and reload it to DRAIN_CYCLES.
- HALTED: pc_write=0, IF_ID_write=0, ID_EX_flush=1, MEM_WB_flush=1, halted=1.
  - resume=1 → RUN at the next edge.
  - halt_req is ignored while HALTED. It is level-sensitive, so it re-halts on the first RUN cycle if still high.
  - resume outside HALTED is ignored.
- stall_cnt increments when pc_write=0 in RUN or DRAIN.
- flush_cnt increments when the branch squash is applied.
- Both counters saturate at all-ones; no wrap.
- Reset mid-DRAIN or mid-stall returns to BOOT immediately with counters cleared.

Decomposition:
- pipe_ctrl_pkg holds:
  - the state enum (2-bit encoding BOOT=0, RUN=1, DRAIN=2, HALTED=3);
  - the x0 register index constant;
  - the DRAIN_CYCLES default.
- One combinational sub-module, load_use_detect (inputs ID_rs1, ID_rs2, uses_rs2, ID_EX_memread, ID_EX_rd; output load_use), is instantiated once.

Test Plan:
- Reset/boot: hold rst_n=0 for 3 cycles, then release → BOOT outputs during reset plus one cycle; RUN on cycle 2 with pc_write=1; counters 0.
- Load-use stall:
  - `lw x5` in EX with `add x6,x5,x7` in ID → one cycle of pc_write=0, IF_ID_write=0, ID_EX_flush=1, then normal; stall_cnt=1.
  - Same with ID_EX_rd=0 → no stall.
  - `addi x6,x5,1` against ID_EX_rd=7 with ID_rs2=7 (uses_rs2=0) → no stall.
- Branch vs load-use collision: EX_branch_taken=1 and load_use=1 in the same cycle → pc_write=1, IF_ID_flush=1, ID_EX_flush=1; flush_cnt=1; stall_cnt unchanged.
- Memory wait: dmem_ready=0 for 4 cycles with EX_MEM_mem_access=1 and EX_branch_taken=1 → 4 frozen cycles with MEM_WB_flush=1; the branch flush is applied on the 5th cycle; stall_cnt=4.
- Halt/resume:
  - halt_req=1 → DRAIN 3 cycles, then halted=1.
  - Inject one mem_stall during DRAIN → drain takes 4 cycles.
  - resume pulse → RUN next cycle with pc_write=1.
- Counter saturation: with CNT_W=4, force 20 stall cycles → stall_cnt sticks at 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer.
//   state_e              : sequencer state, BOOT=0, RUN=1, DRAIN=2, HALTED=3
//   REG_X0               : index of the hard-wired zero register
//   DRAIN_CYCLES_DEFAULT : default number of unfrozen cycles needed to empty EX/MEM/WB
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    StBoot   = 2'd0,
    StRun    = 2'd1,
    StDrain  = 2'd2,
    StHalted = 2'd3
  } state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  localparam int unsigned DRAIN_CYCLES_DEFAULT = 3;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector (combinational).
//   ID_rs1, ID_rs2 : source registers of the instruction in ID
//   uses_rs2       : ID instruction actually reads rs2
//   ID_EX_memread  : instruction in EX is a load
//   ID_EX_rd       : destination of the instruction in EX
//   load_use       : ID must wait one cycle for the load result
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] ID_rs1,
  input  logic [4:0] ID_rs2,
  input  logic       uses_rs2,
  input  logic       ID_EX_memread,
  input  logic [4:0] ID_EX_rd,
  output logic       load_use
);

  // A load into x0 never produces a value, so it cannot create a hazard.
  assign load_use = ID_EX_memread && (ID_EX_rd != REG_X0) &&
                    ((ID_EX_rd == ID_rs1) || (uses_rs2 && (ID_EX_rd == ID_rs2)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer for the 5-stage core: stall, bubble and flush enables for PC, IF/ID,
// ID/EX, EX/MEM and MEM/WB, plus a debug halt/drain/resume handshake and saturating
// stall/flush performance counters.
//   Inputs : ID operand fields, EX load/rd info, EX taken-branch, MEM access/dmem_ready,
//            halt_req (level), resume (pulse)
//   Outputs: register write/flush enables, halted, stall_cnt, flush_cnt
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_alusrc,
  input  logic             ID_memwrite,
  input  logic             ID_EX_memread,
  input  logic [4:0]       ID_EX_rd,
  input  logic             EX_branch_taken,
  input  logic             EX_MEM_mem_access,
  input  logic             dmem_ready,
  input  logic             halt_req,
  input  logic             resume,
  output logic             pc_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_write,
  output logic             ID_EX_flush,
  output logic             EX_MEM_write,
  output logic             MEM_WB_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned DcW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DcW-1:0] DrainInit = DcW'(DRAIN_CYCLES);

  state_e             state_q, state_d;
  logic [DcW-1:0]     drain_q, drain_d;
  logic [CNT_W-1:0]   stall_cnt_q, flush_cnt_q;
  logic               mem_stall, uses_rs2, load_use;
  logic               flush_evt, stall_evt;

  assign mem_stall = EX_MEM_mem_access && !dmem_ready;
  // Stores read rs2 as store data even though operand B is the immediate.
  assign uses_rs2  = !ID_alusrc || ID_memwrite;

  load_use_detect u_load_use_detect (
    .ID_rs1        (ID_rs1),
    .ID_rs2        (ID_rs2),
    .uses_rs2      (uses_rs2),
    .ID_EX_memread (ID_EX_memread),
    .ID_EX_rd      (ID_EX_rd),
    .load_use      (load_use)
  );

  always_comb begin
    pc_write     = 1'b1;
    IF_ID_write  = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_write  = 1'b1;
    ID_EX_flush  = 1'b0;
    EX_MEM_write = 1'b1;
    MEM_WB_flush = 1'b0;
    halted       = 1'b0;
    flush_evt    = 1'b0;
    state_d      = state_q;
    drain_d      = drain_q;
    unique case (state_q)
      StBoot: begin
        pc_write     = 1'b0;
        IF_ID_write  = 1'b0;
        IF_ID_flush  = 1'b1;
        ID_EX_flush  = 1'b1;
        MEM_WB_flush = 1'b1;
        state_d      = StRun;
      end
      StRun, StDrain: begin
        if (mem_stall) begin
          // Whole front of the pipe frozen; branch/hazard re-evaluated next cycle.
          pc_write     = 1'b0;
          IF_ID_write  = 1'b0;
          ID_EX_write  = 1'b0;
          EX_MEM_write = 1'b0;
          MEM_WB_flush = 1'b1;
        end else if (EX_branch_taken) begin
          // Squash overrides load-use and drain hold: the ID instruction is dead anyway.
          pc_write    = 1'b1;
          IF_ID_flush = 1'b1;
          ID_EX_flush = 1'b1;
          flush_evt   = 1'b1;
        end else if (load_use || (state_q == StDrain)) begin
          pc_write    = 1'b0;
          IF_ID_write = 1'b0;
          ID_EX_flush = 1'b1;
        end
        if (state_q == StRun) begin
          if (halt_req && !mem_stall) state_d = StDrain;
        end else if (!mem_stall) begin
          if (drain_q <= DcW'(1)) begin
            state_d = StHalted;
            drain_d = DrainInit;
          end else begin
            drain_d = drain_q - DcW'(1);
          end
        end
      end
      StHalted: begin
        pc_write     = 1'b0;
        IF_ID_write  = 1'b0;
        ID_EX_flush  = 1'b1;
        MEM_WB_flush = 1'b1;
        halted       = 1'b1;
        if (resume) state_d = StRun;
      end
      default: state_d = StBoot;
    endcase
  end

  assign stall_evt = !pc_write && ((state_q == StRun) || (state_q == StDrain));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StBoot;
      drain_q     <= DrainInit;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      if (stall_evt && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_evt && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  localparam int unsigned CntW = 4;

  // Control bundle: {pc_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush,
  //                  EX_MEM_write, MEM_WB_flush, halted}
  localparam logic [7:0] C_BOOT = 8'b0011_1110;
  localparam logic [7:0] C_RUN  = 8'b1101_0100;
  localparam logic [7:0] C_LU   = 8'b0001_1100;
  localparam logic [7:0] C_HOLD = 8'b0001_1100;
  localparam logic [7:0] C_BR   = 8'b1111_1100;
  localparam logic [7:0] C_MS   = 8'b0000_0010;
  localparam logic [7:0] C_HALT = 8'b0001_1111;

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       alusrc, memwrite, memread;
    logic [4:0] rd;
    logic       br, macc, dready, halt, res;
    logic [7:0] ctl;
    int         stall, flush;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] ctl;
    int         stall, flush;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [4:0]      ID_rs1, ID_rs2, ID_EX_rd;
  logic            ID_alusrc, ID_memwrite, ID_EX_memread;
  logic            EX_branch_taken, EX_MEM_mem_access, dmem_ready, halt_req, resume;
  logic            pc_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush;
  logic            EX_MEM_write, MEM_WB_flush, halted;
  logic [CntW-1:0] stall_cnt, flush_cnt;
  logic [7:0]      ctl;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  assign ctl = {pc_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush,
                EX_MEM_write, MEM_WB_flush, halted};

  pipeline_ctrl #(.CNT_W(CntW), .DRAIN_CYCLES(3)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ID_rs1            (ID_rs1),
    .ID_rs2            (ID_rs2),
    .ID_alusrc         (ID_alusrc),
    .ID_memwrite       (ID_memwrite),
    .ID_EX_memread     (ID_EX_memread),
    .ID_EX_rd          (ID_EX_rd),
    .EX_branch_taken   (EX_branch_taken),
    .EX_MEM_mem_access (EX_MEM_mem_access),
    .dmem_ready        (dmem_ready),
    .halt_req          (halt_req),
    .resume            (resume),
    .pc_write          (pc_write),
    .IF_ID_write       (IF_ID_write),
    .IF_ID_flush       (IF_ID_flush),
    .ID_EX_write       (ID_EX_write),
    .ID_EX_flush       (ID_EX_flush),
    .EX_MEM_write      (EX_MEM_write),
    .MEM_WB_flush      (MEM_WB_flush),
    .halted            (halted),
    .stall_cnt         (stall_cnt),
    .flush_cnt         (flush_cnt)
  );

  function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic alusrc,
                              input logic memwrite, input logic memread, input logic [4:0] rd,
                              input logic br, input logic macc, input logic dready,
                              input logic halt, input logic res, input logic [7:0] c,
                              input int s, input int f);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.alusrc = alusrc; v.memwrite = memwrite; v.memread = memread;
    v.rd = rd; v.br = br; v.macc = macc; v.dready = dready; v.halt = halt; v.res = res;
    v.ctl = c; v.stall = s; v.flush = f;
    return v;
  endfunction

  function automatic vec_t idle(input logic [7:0] c, input int s, input int f);
    return mk(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, c, s, f);
  endfunction

  task automatic drive(input vec_t v);
    ID_rs1 = v.rs1; ID_rs2 = v.rs2; ID_alusrc = v.alusrc; ID_memwrite = v.memwrite;
    ID_EX_memread = v.memread; ID_EX_rd = v.rd; EX_branch_taken = v.br;
    EX_MEM_mem_access = v.macc; dmem_ready = v.dready; halt_req = v.halt; resume = v.res;
  endtask

  task automatic push(input string name, input logic [7:0] c, input int s, input int f);
    exp_t e;
    e.name = name; e.ctl = c; e.stall = s; e.flush = f;
    sb.push_back(e);
  endtask

  task automatic compare(input string name, input logic [7:0] c, input int s, input int f);
    n_tests += 3;
    if (ctl !== c) begin
      n_fail++;
      $display("FAIL %s ctl: got %b, expected %b", name, ctl, c);
    end
    if (stall_cnt !== CntW'(s)) begin
      n_fail++;
      $display("FAIL %s stall_cnt: got %0d, expected %0d", name, stall_cnt, s);
    end
    if (flush_cnt !== CntW'(f)) begin
      n_fail++;
      $display("FAIL %s flush_cnt: got %0d, expected %0d", name, flush_cnt, f);
    end
  endtask

  // Scoreboard: outputs are combinational, so each cycle's expectation is checked mid-cycle.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      compare(e.name, e.ctl, e.stall, e.flush);
    end
  end

  // Apply one vector after the active edge and queue its expectation.
  task automatic step(input string name, input vec_t v);
    @(posedge clk);
    #1;
    drive(v);
    push(name, v.ctl, v.stall, v.flush);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(idle(C_RUN, 0, 0));

    // Table: RUN hazards, branch collision, memory wait, halt/drain/resume.
    vecs.push_back(idle(C_RUN, 0, 0));                                                    // 0
    vecs.push_back(mk(5, 7, 0, 0, 1, 5, 0, 0, 1, 0, 0, C_LU, 0, 0));                      // 1 lw/add
    vecs.push_back(mk(5, 7, 0, 0, 0, 5, 0, 0, 1, 0, 0, C_RUN, 1, 0));                     // 2
    vecs.push_back(mk(0, 7, 0, 0, 1, 0, 0, 0, 1, 0, 0, C_RUN, 1, 0));                     // 3 rd=x0
    vecs.push_back(mk(5, 7, 1, 0, 1, 7, 0, 0, 1, 0, 0, C_RUN, 1, 0));                     // 4 addi
    vecs.push_back(mk(5, 7, 1, 1, 1, 7, 0, 0, 1, 0, 0, C_LU, 1, 0));                      // 5 store
    vecs.push_back(mk(3, 9, 0, 0, 1, 9, 0, 0, 1, 0, 0, C_LU, 2, 0));                      // 6 rs2
    vecs.push_back(mk(5, 7, 0, 0, 1, 5, 1, 0, 1, 0, 0, C_BR, 3, 0));                      // 7 br+lu
    vecs.push_back(idle(C_RUN, 3, 1));                                                    // 8
    for (int i = 0; i < 4; i++)                                                           // 9-12
      vecs.push_back(mk(1, 2, 0, 0, 0, 0, 1, 1, 0, 0, 0, C_MS, 3 + i, 1));
    vecs.push_back(mk(1, 2, 0, 0, 0, 0, 1, 1, 1, 0, 0, C_BR, 7, 1));                      // 13
    vecs.push_back(idle(C_RUN, 7, 2));                                                    // 14
    vecs.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_RUN, 7, 2));                     // 15 halt
    for (int i = 0; i < 3; i++)                                                           // 16-18
      vecs.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_HOLD, 7 + i, 2));
    vecs.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_HALT, 10, 2));                   // 19
    vecs.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 1, C_HALT, 10, 2));                   // 20 resume
    vecs.push_back(idle(C_RUN, 10, 2));                                                   // 21
    vecs.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_RUN, 10, 2));                    // 22 halt
    vecs.push_back(mk(1, 2, 0, 0, 0, 0, 1, 0, 1, 0, 0, C_BR, 10, 2));                     // 23 br
    vecs.push_back(mk(1, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0, C_MS, 10, 3));                     // 24 mem
    vecs.push_back(idle(C_HOLD, 11, 3));                                                  // 25
    vecs.push_back(idle(C_HOLD, 12, 3));                                                  // 26
    vecs.push_back(mk(1, 2, 0, 0, 0, 0, 1, 0, 1, 0, 0, C_HALT, 13, 3));                   // 27
    vecs.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 1, C_HALT, 13, 3));                   // 28
    vecs.push_back(idle(C_RUN, 13, 3));                                                   // 29
    vecs.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 1, C_RUN, 13, 3));                    // 30
    vecs.push_back(idle(C_RUN, 13, 3));                                                   // 31

    // Reset held for 3 cycles: BOOT outputs and cleared counters.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      push("reset", C_BOOT, 0, 0);
    end
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    compare("boot", C_BOOT, 0, 0);

    for (int i = 0; i < vecs.size(); i++) step($sformatf("vec%0d", i), vecs[i]);

    // Saturation: 20 consecutive load-use stalls.
    for (int i = 0; i < 20; i++)
      step($sformatf("sat%0d", i), mk(5, 7, 0, 0, 1, 5, 0, 0, 1, 0, 0, C_LU,
                                      (13 + i > 15) ? 15 : 13 + i, 3));
    step("sat_idle", idle(C_RUN, 15, 3));

    // Reset asserted mid-DRAIN.
    step("pre_drain", mk(1, 2, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_RUN, 15, 3));
    step("in_drain", mk(1, 2, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_HOLD, 15, 3));
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    compare("async_rst", C_BOOT, 0, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    compare("boot2", C_BOOT, 0, 0);
    step("rerun", mk(1, 2, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_RUN, 0, 0));
    for (int i = 0; i < 3; i++)
      step($sformatf("redrain%0d", i), mk(1, 2, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_HOLD, i, 0));
    step("rehalt", idle(C_HALT, 3, 0));
    step("reresume", mk(1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 1, C_HALT, 3, 0));
    step("rerun2", idle(C_RUN, 3, 0));

    @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
